// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the MIPS-subset control path.
// Holds the opcode constants, ALUOp encodings, the bit positions of the
// 8-bit control bundle, and the packed bundle struct. The ALU-control and
// datapath blocks reuse the same struct.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [1:0] ALUOP_ADD   = 2'b01;
    localparam logic [1:0] ALUOP_OR    = 2'b10;
    localparam logic [1:0] ALUOP_SUB   = 2'b11;

    // Bit positions inside the 8-bit bundle
    localparam int CB_REG_WRITE  = 0;
    localparam int CB_MEM_TO_REG = 1;
    localparam int CB_MEM_READ   = 2;
    localparam int CB_MEM_WRITE  = 3;
    localparam int CB_ALU_OP_LO  = 4;
    localparam int CB_ALU_OP_HI  = 5;
    localparam int CB_ALU_SRC    = 6;
    localparam int CB_REG_DST    = 7;

    // Field order matches the CB_* positions (MSB first)
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    // Instructions that read rt as a source operand (sw reads rt as store data)
    function automatic logic uses_rt_src(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use hazard detection.
// Ports:
//   i_ex_memread  MemRead of the instruction currently in ID/EX
//   i_ex_rt       destination (rt) of the instruction in ID/EX
//   i_op          opcode in ID
//   i_rs, i_rt    source fields in ID
//   o_stall       hold PC and IF/ID, bubble ID/EX
module hazard_detect
    import ctrl_pkg::*;
#(
    parameter int HAZARD_EN = 1
) (
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_rt,
    input  logic [5:0] i_op,
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    output logic       o_stall
);

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_hazard;

    // j carries target bits in the rs field, so it must not match on rs
    assign w_rs_hit = (i_ex_rt == i_rs) && (i_op != OP_J);
    assign w_rt_hit = (i_ex_rt == i_rt) && uses_rt_src(i_op);
    // $zero is never a real dependency
    assign w_hazard = i_ex_memread && (i_ex_rt != 5'd0) && (w_rs_hit || w_rt_hit);

    assign o_stall = (HAZARD_EN != 0) ? w_hazard : 1'b0;

endmodule

// File: rtl/pipe_control.sv
// pipe_control: pipelined main control for the MIPS-subset CPU.
// Decodes the ID opcode into the control bundle, carries it through
// ID/EX, EX/MEM and MEM/WB, inserts load-use bubbles and resolves beq/j in ID.
// Ports:
//   clk_i, rst_i       clock (rising edge), async active-low reset
//   op_i, rs_i, rt_i   ID instruction fields; eq_i = (rs == rt) from ID
//   id_ctrl_o          combinational bundle, zero-extended to CTRL_W
//   ex_ctrl_o          {RegDst, ALUSrc, ALUOp} from ID/EX
//   mem_ctrl_o         {MemWrite, MemRead} from EX/MEM
//   wb_ctrl_o          {MemtoReg, RegWrite} from MEM/WB
//   stall_o, branch_o, jump_o, flush_o   hazard and PC control
//   illegal_o          sticky unknown-opcode flag
module pipe_control
    import ctrl_pkg::*;
#(
    parameter int CTRL_W    = 32,
    parameter int HAZARD_EN = 1,
    parameter int BRANCH_EN = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [5:0]        op_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic              eq_i,
    output logic [CTRL_W-1:0] id_ctrl_o,
    output logic [3:0]        ex_ctrl_o,
    output logic [1:0]        mem_ctrl_o,
    output logic [1:0]        wb_ctrl_o,
    output logic              stall_o,
    output logic              branch_o,
    output logic              jump_o,
    output logic              flush_o,
    output logic              illegal_o
);

    ctrl_t      w_dec;
    logic [7:0] w_dec_bits;
    logic       w_illegal_op;
    logic       w_stall;

    logic [7:0] r_idex;
    logic [4:0] r_ex_rt;
    logic [3:0] r_exmem;    // {MemWrite, MemRead, MemtoReg, RegWrite}
    logic [1:0] r_memwb;    // {MemtoReg, RegWrite}
    logic       r_illegal;

    always_comb begin
        w_dec        = '0;
        w_illegal_op = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                w_dec.reg_dst   = 1'b1;
                w_dec.alu_op    = ALUOP_RTYPE;
                w_dec.reg_write = 1'b1;
            end
            OP_ADDI: begin
                w_dec.alu_src   = 1'b1;
                w_dec.alu_op    = ALUOP_ADD;
                w_dec.reg_write = 1'b1;
            end
            OP_ORI: begin
                w_dec.alu_src   = 1'b1;
                w_dec.alu_op    = ALUOP_OR;
                w_dec.reg_write = 1'b1;
            end
            OP_LW: begin
                w_dec.alu_src    = 1'b1;
                w_dec.alu_op     = ALUOP_ADD;
                w_dec.mem_read   = 1'b1;
                w_dec.mem_to_reg = 1'b1;
                w_dec.reg_write  = 1'b1;
            end
            OP_SW: begin
                w_dec.alu_src   = 1'b1;
                w_dec.alu_op    = ALUOP_ADD;
                w_dec.mem_write = 1'b1;
            end
            OP_BEQ: begin
                w_dec.alu_op = ALUOP_SUB;
            end
            OP_J: begin
                w_illegal_op = 1'b0;
            end
            default: begin
                w_illegal_op = 1'b1;
            end
        endcase
    end

    assign w_dec_bits = w_dec;

    always_comb begin
        id_ctrl_o      = '0;
        id_ctrl_o[7:0] = w_dec_bits;
    end

    hazard_detect #(
        .HAZARD_EN(HAZARD_EN)
    ) u_hazard_detect (
        .i_ex_memread(r_idex[CB_MEM_READ]),
        .i_ex_rt     (r_ex_rt),
        .i_op        (op_i),
        .i_rs        (rs_i),
        .i_rt        (rt_i),
        .o_stall     (w_stall)
    );

    // A stalled beq/j is re-evaluated next cycle, so stall masks both
    assign stall_o  = w_stall;
    assign branch_o = (BRANCH_EN != 0) && (op_i == OP_BEQ) && eq_i && !w_stall;
    assign jump_o   = (BRANCH_EN != 0) && (op_i == OP_J) && !w_stall;
    assign flush_o  = branch_o || jump_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_idex    <= '0;
            r_ex_rt   <= '0;
            r_exmem   <= '0;
            r_memwb   <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_stall) begin
                r_idex  <= '0;
                r_ex_rt <= '0;
            end else begin
                r_idex  <= w_dec_bits;
                r_ex_rt <= rt_i;
            end
            r_exmem <= {r_idex[CB_MEM_WRITE], r_idex[CB_MEM_READ],
                        r_idex[CB_MEM_TO_REG], r_idex[CB_REG_WRITE]};
            r_memwb <= r_exmem[1:0];
            if (w_illegal_op) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign ex_ctrl_o  = {r_idex[CB_REG_DST], r_idex[CB_ALU_SRC],
                         r_idex[CB_ALU_OP_HI:CB_ALU_OP_LO]};
    assign mem_ctrl_o = r_exmem[3:2];
    assign wb_ctrl_o  = r_memwb;
    assign illegal_o  = r_illegal;

endmodule

// File: tb/tb_pipe_control.sv
module tb_pipe_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    localparam logic [7:0] B_R    = 8'b1000_0001;
    localparam logic [7:0] B_ADDI = 8'b0101_0001;
    localparam logic [7:0] B_ORI  = 8'b0110_0001;
    localparam logic [7:0] B_LW   = 8'b0101_0111;
    localparam logic [7:0] B_SW   = 8'b0101_1000;
    localparam logic [7:0] B_BEQ  = 8'b0011_0000;
    localparam logic [7:0] B_ZERO = 8'b0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [5:0]  op_i;
    logic [4:0]  rs_i;
    logic [4:0]  rt_i;
    logic        eq_i;
    logic [31:0] id_ctrl_o;
    logic [3:0]  ex_ctrl_o;
    logic [1:0]  mem_ctrl_o;
    logic [1:0]  wb_ctrl_o;
    logic        stall_o;
    logic        branch_o;
    logic        jump_o;
    logic        flush_o;
    logic        illegal_o;

    int n_checks = 0;
    int n_fail   = 0;

    // expected pipeline contents
    logic [7:0] m_idex;
    logic [3:0] m_exmem;
    logic [1:0] m_memwb;
    logic       m_illegal;

    pipe_control #(
        .CTRL_W(32), .HAZARD_EN(1), .BRANCH_EN(1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .rs_i(rs_i), .rt_i(rt_i),
        .eq_i(eq_i), .id_ctrl_o(id_ctrl_o), .ex_ctrl_o(ex_ctrl_o),
        .mem_ctrl_o(mem_ctrl_o), .wb_ctrl_o(wb_ctrl_o), .stall_o(stall_o),
        .branch_o(branch_o), .jump_o(jump_o), .flush_o(flush_o),
        .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_idex    = '0;
        m_exmem   = '0;
        m_memwb   = '0;
        m_illegal = 1'b0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_ex"},  {28'd0, ex_ctrl_o},  {28'd0, m_idex[7:4]});
        chk({tag, "_mem"}, {30'd0, mem_ctrl_o}, {30'd0, m_exmem[3:2]});
        chk({tag, "_wb"},  {30'd0, wb_ctrl_o},  {30'd0, m_memwb});
        chk({tag, "_ill"}, {31'd0, illegal_o},  {31'd0, m_illegal});
    endtask

    // One ID cycle: drive, check combinational outputs, clock, check registers.
    task automatic cyc(input string tag, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic eq, input logic [7:0] exp_id,
                       input logic exp_stall, input logic exp_br, input logic exp_j,
                       input logic exp_bad);
        op_i = op; rs_i = rs; rt_i = rt; eq_i = eq;
        #1;
        chk({tag, "_id"},    id_ctrl_o, {24'd0, exp_id});
        chk({tag, "_stall"}, {31'd0, stall_o},  {31'd0, exp_stall});
        chk({tag, "_br"},    {31'd0, branch_o}, {31'd0, exp_br});
        chk({tag, "_jmp"},   {31'd0, jump_o},   {31'd0, exp_j});
        chk({tag, "_flush"}, {31'd0, flush_o},  {31'd0, exp_br | exp_j});
        @(posedge clk_i);
        #1;
        m_memwb = m_exmem[1:0];
        m_exmem = m_idex[3:0];
        m_idex  = exp_stall ? 8'h00 : exp_id;
        if (exp_bad) m_illegal = 1'b1;
        chk_regs(tag);
    endtask

    initial begin
        model_clear();
        rst_i = 1'b0;
        op_i = 6'($urandom); rs_i = 5'($urandom); rt_i = 5'($urandom); eq_i = 1'b0;
        #2;
        chk_regs("rst0");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            op_i = (i == 1) ? OP_BAD : 6'($urandom);
            rs_i = 5'($urandom); rt_i = 5'($urandom);
            @(posedge clk_i);
            #1;
            chk_regs("rst_hold");
        end
        rst_i = 1'b1;

        // lw reaches write-back exactly three cycles later
        cyc("lw0", OP_LW, 5'd1, 5'd2, 1'b0, B_LW, 0, 0, 0, 0);
        chk("lw_wb1", {30'd0, wb_ctrl_o}, 32'd0);
        cyc("f1",  OP_R,  5'd0, 5'd0, 1'b0, B_R, 0, 0, 0, 0);
        chk("lw_wb2", {30'd0, wb_ctrl_o}, 32'd0);
        cyc("f2",  OP_R,  5'd0, 5'd0, 1'b0, B_R, 0, 0, 0, 0);
        chk("lw_wb3", {30'd0, wb_ctrl_o}, 32'd3);

        // decode sweep, no dependencies
        cyc("addi", OP_ADDI, 5'd0, 5'd0, 1'b0, B_ADDI, 0, 0, 0, 0);
        cyc("ori",  OP_ORI,  5'd0, 5'd0, 1'b0, B_ORI,  0, 0, 0, 0);
        cyc("lw",   OP_LW,   5'd0, 5'd0, 1'b0, B_LW,   0, 0, 0, 0);
        cyc("sw",   OP_SW,   5'd0, 5'd0, 1'b0, B_SW,   0, 0, 0, 0);
        cyc("beq0", OP_BEQ,  5'd0, 5'd0, 1'b0, B_BEQ,  0, 0, 0, 0);
        cyc("j",    OP_J,    5'd0, 5'd0, 1'b0, B_ZERO, 0, 0, 1, 0);
        cyc("rt",   OP_R,    5'd0, 5'd0, 1'b0, B_R,    0, 0, 0, 0);
        cyc("f3",   OP_R,    5'd0, 5'd0, 1'b0, B_R,    0, 0, 0, 0);
        cyc("f4",   OP_R,    5'd0, 5'd0, 1'b0, B_R,    0, 0, 0, 0);

        // load-use on rs: one bubble, then release
        cyc("lu_lw",  OP_LW, 5'd0, 5'd5, 1'b0, B_LW, 0, 0, 0, 0);
        cyc("lu_st",  OP_R,  5'd5, 5'd0, 1'b0, B_R,  1, 0, 0, 0);
        chk("lu_bubble", {28'd0, ex_ctrl_o}, 32'd0);
        cyc("lu_go",  OP_R,  5'd5, 5'd0, 1'b0, B_R,  0, 0, 0, 0);
        // rt = 0 is never a dependency
        cyc("z_lw",   OP_LW, 5'd0, 5'd0, 1'b0, B_LW, 0, 0, 0, 0);
        cyc("z_use",  OP_R,  5'd0, 5'd0, 1'b0, B_R,  0, 0, 0, 0);
        // rt compare applies to sw but not to addi
        cyc("sw_lw",  OP_LW,   5'd0, 5'd7, 1'b0, B_LW,   0, 0, 0, 0);
        cyc("sw_st",  OP_SW,   5'd1, 5'd7, 1'b0, B_SW,   1, 0, 0, 0);
        cyc("sw_go",  OP_SW,   5'd1, 5'd7, 1'b0, B_SW,   0, 0, 0, 0);
        cyc("ad_lw",  OP_LW,   5'd0, 5'd7, 1'b0, B_LW,   0, 0, 0, 0);
        cyc("ad_ok",  OP_ADDI, 5'd1, 5'd7, 1'b0, B_ADDI, 0, 0, 0, 0);
        // j ignores its rs field
        cyc("j_lw",   OP_LW, 5'd0, 5'd4, 1'b0, B_LW,   0, 0, 0, 0);
        cyc("j_ok",   OP_J,  5'd4, 5'd0, 1'b0, B_ZERO, 0, 0, 1, 0);

        // branch resolution
        cyc("beq_t",  OP_BEQ, 5'd0, 5'd0, 1'b1, B_BEQ, 0, 1, 0, 0);
        cyc("beq_n",  OP_BEQ, 5'd0, 5'd0, 1'b0, B_BEQ, 0, 0, 0, 0);

        // stall beats branch, branch resolves the following cycle
        cyc("sb_lw",  OP_LW,  5'd0, 5'd3, 1'b0, B_LW,  0, 0, 0, 0);
        cyc("sb_st",  OP_BEQ, 5'd3, 5'd0, 1'b1, B_BEQ, 1, 0, 0, 0);
        cyc("sb_br",  OP_BEQ, 5'd3, 5'd0, 1'b1, B_BEQ, 0, 1, 0, 0);

        // illegal opcode is sticky until reset
        cyc("bad",    OP_BAD, 5'd0, 5'd0, 1'b0, B_ZERO, 0, 0, 0, 1);
        cyc("bad_h1", OP_R,   5'd0, 5'd0, 1'b0, B_R,    0, 0, 0, 0);
        cyc("bad_h2", OP_LW,  5'd0, 5'd9, 1'b0, B_LW,   0, 0, 0, 0);

        // asynchronous reset mid-cycle drops in-flight writes at once
        #2;
        rst_i = 1'b0;
        #1;
        model_clear();
        chk_regs("arst");
        @(posedge clk_i);
        #1;
        chk_regs("arst_edge");
        rst_i = 1'b1;
        cyc("post", OP_R, 5'd9, 5'd0, 1'b0, B_R, 0, 0, 0, 0);
        cyc("post2", OP_R, 5'd0, 5'd0, 1'b0, B_R, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
